// File: rtl/fall_detect_pkg.sv
// fall_detect_pkg: state encodings and default thresholds for the fall detection chain.
package fall_detect_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE        = 3'd0,
        FREEFALL    = 3'd1,
        WAIT_IMPACT = 3'd2,
        POST_IMPACT = 3'd3,
        ALARM       = 3'd4
    } state_t;

    // Raw LSB values for a +/-4 g sensor, 1 g = 8192
    localparam logic [15:0] FF_THRESH_DEF     = 16'd3277;
    localparam logic [15:0] IMPACT_THRESH_DEF = 16'd20480;
    localparam logic [15:0] STILL_LO_DEF      = 16'd6554;
    localparam logic [15:0] STILL_HI_DEF      = 16'd9830;
    localparam logic [15:0] ONE_G             = 16'd8192;

    function automatic logic in_band(input logic [15:0] m, input logic [15:0] lo, input logic [15:0] hi);
        return (m >= lo) && (m <= hi);
    endfunction

endpackage

// File: rtl/fall_detect_fsm_sat_counter.sv
// sat_counter: up-counter that stops at max and clears synchronously, clear winning over increment.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] max,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count < max)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/fall_detect_fsm.sv
// fall_detect_fsm: free-fall / impact / stillness signature detector on the |a| sample stream.
module fall_detect_fsm
    import fall_detect_pkg::*;
#(
    parameter logic [15:0] FF_THRESH      = FF_THRESH_DEF,
    parameter logic [15:0] IMPACT_THRESH  = IMPACT_THRESH_DEF,
    parameter logic [15:0] STILL_LO       = STILL_LO_DEF,
    parameter logic [15:0] STILL_HI       = STILL_HI_DEF,
    parameter int unsigned FF_MIN_SAMPLES = 8,
    parameter int unsigned IMPACT_WINDOW  = 50,
    parameter int unsigned STILL_SAMPLES  = 100,
    parameter int unsigned POST_WINDOW    = 300
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [15:0]        magnitude,
    input  logic               mag_valid,
    input  logic               clear_alarm,
    output logic               fall_detected,
    output logic               fall_flag,
    output logic [15:0]        peak_mag,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int FW = $clog2(FF_MIN_SAMPLES + 1);
    localparam int WW = $clog2(IMPACT_WINDOW + 1);
    localparam int SW = $clog2(STILL_SAMPLES + 1);
    localparam int PW = $clog2(POST_WINDOW + 1);

    localparam logic [FW-1:0] FF_MAX     = FW'(FF_MIN_SAMPLES);
    localparam logic [WW-1:0] WIN_MAX    = WW'(IMPACT_WINDOW);
    localparam logic [SW-1:0] STILL_MAX  = SW'(STILL_SAMPLES);
    localparam logic [PW-1:0] POST_MAX   = PW'(POST_WINDOW);
    localparam logic [WW-1:0] WIN_LAST   = WW'(IMPACT_WINDOW - 1);
    localparam logic [SW-1:0] STILL_LAST = SW'(STILL_SAMPLES - 1);
    localparam logic [PW-1:0] POST_LAST  = PW'(POST_WINDOW - 1);

    state_t        state, state_nxt;
    logic [FW-1:0] ff_cnt;
    logic [WW-1:0] win_cnt;
    logic [SW-1:0] still_cnt;
    logic [PW-1:0] post_cnt;
    logic          low, impact, band, ff_ok;
    logic          ff_inc, win_inc, post_inc, clr_all;

    assign low     = magnitude < FF_THRESH;
    assign impact  = magnitude >= IMPACT_THRESH;
    assign band    = in_band(magnitude, STILL_LO, STILL_HI);
    assign ff_ok   = ff_cnt >= FF_MAX;
    assign clr_all = state_nxt == IDLE;

    // Terminal checks use the pre-increment count so a limit is acted on by the sample that reaches it
    always_comb begin
        state_nxt = state;
        ff_inc    = 1'b0;
        win_inc   = 1'b0;
        post_inc  = 1'b0;
        if (clear_alarm)
            state_nxt = IDLE;
        else if (mag_valid) begin
            case (state)
                IDLE: begin
                    ff_inc    = low;
                    state_nxt = low ? FREEFALL : IDLE;
                end
                FREEFALL: begin
                    ff_inc    = low;
                    win_inc   = !low && ff_ok && !impact;
                    state_nxt = low ? FREEFALL : !ff_ok ? IDLE : impact ? POST_IMPACT : WAIT_IMPACT;
                end
                WAIT_IMPACT: begin
                    win_inc   = !impact;
                    state_nxt = impact ? POST_IMPACT : (win_cnt == WIN_LAST) ? IDLE : WAIT_IMPACT;
                end
                POST_IMPACT: begin
                    post_inc  = 1'b1;
                    state_nxt = (band && still_cnt == STILL_LAST) ? ALARM :
                                (post_cnt == POST_LAST) ? IDLE : POST_IMPACT;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            fall_detected <= 1'b0;
            peak_mag      <= '0;
        end else begin
            state         <= state_nxt;
            fall_detected <= state_nxt == ALARM && state != ALARM;
            if (mag_valid && !clear_alarm && state == POST_IMPACT)
                peak_mag <= (magnitude > peak_mag) ? magnitude : peak_mag;
            else if (state != POST_IMPACT && state_nxt == POST_IMPACT)
                peak_mag <= magnitude;
        end
    end

    assign fall_flag = state == ALARM;
    assign state_dbg = state;

    sat_counter #(.W(FW)) u_ff (
        .clk(clk), .reset_n(reset_n), .inc(ff_inc), .clr(clr_all), .max(FF_MAX), .count(ff_cnt)
    );

    sat_counter #(.W(WW)) u_win (
        .clk(clk), .reset_n(reset_n), .inc(win_inc), .clr(clr_all), .max(WIN_MAX), .count(win_cnt)
    );

    // Any out-of-band sample restarts the stillness run
    sat_counter #(.W(SW)) u_still (
        .clk(clk), .reset_n(reset_n), .inc(post_inc && band), .clr(clr_all || (post_inc && !band)),
        .max(STILL_MAX), .count(still_cnt)
    );

    sat_counter #(.W(PW)) u_post (
        .clk(clk), .reset_n(reset_n), .inc(post_inc), .clr(clr_all), .max(POST_MAX), .count(post_cnt)
    );

endmodule

// File: tb/tb_fall_detect_fsm.sv
// tb_fall_detect_fsm: directed vector table plus gapped-sample and async-reset sequences.
module tb_fall_detect_fsm;

    typedef struct {
        logic        clr;
        logic        vld;
        logic [15:0] mag;
        logic        det;
        logic        flag;
        logic [15:0] peak;
        logic [2:0]  st;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] magnitude = '0;
    logic        mag_valid = 1'b0;
    logic        clear_alarm = 1'b0;
    logic        fall_detected;
    logic        fall_flag;
    logic [15:0] peak_mag;
    logic [2:0]  state_dbg;

    int compared = 0;
    int mismatched = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fall_detect_fsm #(
        .FF_MIN_SAMPLES(3),
        .IMPACT_WINDOW(4),
        .STILL_SAMPLES(3),
        .POST_WINDOW(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .magnitude(magnitude),
        .mag_valid(mag_valid),
        .clear_alarm(clear_alarm),
        .fall_detected(fall_detected),
        .fall_flag(fall_flag),
        .peak_mag(peak_mag),
        .state_dbg(state_dbg)
    );

    function automatic vec_t mk(logic c, logic v, logic [15:0] m, logic d, logic f, logic [15:0] p, logic [2:0] s);
        vec_t r;
        r.clr = c; r.vld = v; r.mag = m; r.det = d; r.flag = f; r.peak = p; r.st = s;
        return r;
    endfunction

    task automatic check(string name, logic [15:0] got, logic [15:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(string name, logic d, logic f, logic [15:0] p, logic [2:0] s);
        check({name, " state"}, 16'(state_dbg), 16'(s));
        check({name, " flag"}, 16'(fall_flag), 16'(f));
        check({name, " det"}, 16'(fall_detected), 16'(d));
        check({name, " peak"}, peak_mag, p);
    endtask

    task automatic drive(logic c, logic v, logic [15:0] m);
        @(negedge clk);
        clear_alarm = c;
        mag_valid   = v;
        magnitude   = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] seq_mag[7];
        logic [2:0]  seq_st[7];
        logic [2:0]  prev_st;

        // full fall
        vecs.push_back(mk(0, 1, 1000,  0, 0, 0,     1));
        vecs.push_back(mk(0, 1, 1000,  0, 0, 0,     1));
        vecs.push_back(mk(0, 1, 1000,  0, 0, 0,     1));
        vecs.push_back(mk(0, 1, 25000, 0, 0, 25000, 3));
        vecs.push_back(mk(0, 1, 8192,  0, 0, 25000, 3));
        vecs.push_back(mk(0, 1, 8192,  0, 0, 25000, 3));
        vecs.push_back(mk(0, 1, 8192,  1, 1, 25000, 4));
        vecs.push_back(mk(0, 0, 0,     0, 1, 25000, 4));
        vecs.push_back(mk(0, 1, 1000,  0, 1, 25000, 4));
        vecs.push_back(mk(1, 0, 0,     0, 0, 25000, 0));
        // short free-fall
        vecs.push_back(mk(0, 1, 1000,  0, 0, 25000, 1));
        vecs.push_back(mk(0, 1, 1000,  0, 0, 25000, 1));
        vecs.push_back(mk(0, 1, 25000, 0, 0, 25000, 0));
        // impact timeout, then late impact ignored
        vecs.push_back(mk(0, 1, 1000,  0, 0, 25000, 1));
        vecs.push_back(mk(0, 1, 1000,  0, 0, 25000, 1));
        vecs.push_back(mk(0, 1, 1000,  0, 0, 25000, 1));
        vecs.push_back(mk(0, 1, 8192,  0, 0, 25000, 2));
        vecs.push_back(mk(0, 1, 8192,  0, 0, 25000, 2));
        vecs.push_back(mk(0, 1, 8192,  0, 0, 25000, 2));
        vecs.push_back(mk(0, 1, 8192,  0, 0, 25000, 0));
        vecs.push_back(mk(0, 1, 25000, 0, 0, 25000, 0));
        // renewed low in window, boundary impact, then no stillness
        vecs.push_back(mk(0, 1, 1000,  0, 0, 25000, 1));
        vecs.push_back(mk(0, 1, 1000,  0, 0, 25000, 1));
        vecs.push_back(mk(0, 1, 1000,  0, 0, 25000, 1));
        vecs.push_back(mk(0, 1, 8192,  0, 0, 25000, 2));
        vecs.push_back(mk(0, 1, 1000,  0, 0, 25000, 2));
        vecs.push_back(mk(0, 1, 20480, 0, 0, 20480, 3));
        vecs.push_back(mk(0, 1, 8192,  0, 0, 20480, 3));
        vecs.push_back(mk(0, 1, 30000, 0, 0, 30000, 3));
        vecs.push_back(mk(0, 1, 8192,  0, 0, 30000, 3));
        vecs.push_back(mk(0, 1, 15000, 0, 0, 30000, 3));
        vecs.push_back(mk(0, 1, 8192,  0, 0, 30000, 3));
        vecs.push_back(mk(0, 1, 15000, 0, 0, 30000, 3));
        vecs.push_back(mk(0, 1, 8192,  0, 0, 30000, 3));
        vecs.push_back(mk(0, 1, 15000, 0, 0, 30000, 0));
        // band edges; alarm and window end on the same sample
        vecs.push_back(mk(0, 1, 1000,  0, 0, 30000, 1));
        vecs.push_back(mk(0, 1, 1000,  0, 0, 30000, 1));
        vecs.push_back(mk(0, 1, 1000,  0, 0, 30000, 1));
        vecs.push_back(mk(0, 1, 25000, 0, 0, 25000, 3));
        vecs.push_back(mk(0, 1, 9830,  0, 0, 25000, 3));
        vecs.push_back(mk(0, 1, 6554,  0, 0, 25000, 3));
        vecs.push_back(mk(0, 1, 6553,  0, 0, 25000, 3));
        vecs.push_back(mk(0, 1, 9830,  0, 0, 25000, 3));
        vecs.push_back(mk(0, 1, 9831,  0, 0, 25000, 3));
        vecs.push_back(mk(0, 1, 9830,  0, 0, 25000, 3));
        vecs.push_back(mk(0, 1, 6554,  0, 0, 25000, 3));
        vecs.push_back(mk(0, 1, 8192,  1, 1, 25000, 4));
        // clear priority and free-fall threshold edge
        vecs.push_back(mk(1, 1, 1000,  0, 0, 25000, 0));
        vecs.push_back(mk(1, 1, 1000,  0, 0, 25000, 0));
        vecs.push_back(mk(0, 1, 3277,  0, 0, 25000, 0));
        vecs.push_back(mk(0, 1, 3276,  0, 0, 25000, 1));
        vecs.push_back(mk(1, 0, 0,     0, 0, 25000, 0));

        #3;
        check_all("reset", 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].vld, vecs[i].mag);
            check_all($sformatf("vec%0d", i), vecs[i].det, vecs[i].flag, vecs[i].peak, vecs[i].st);
        end

        // gapped full fall: idle cycles must not move anything
        seq_mag = '{16'd1000, 16'd1000, 16'd1000, 16'd25000, 16'd8192, 16'd8192, 16'd8192};
        seq_st  = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd4};
        prev_st = 3'd0;
        for (int i = 0; i < 7; i++) begin
            int gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                drive(0, 0, 16'd0);
                check($sformatf("gap%0d.%0d state", i, g), 16'(state_dbg), 16'(prev_st));
                check($sformatf("gap%0d.%0d det", i, g), 16'(fall_detected), 16'd0);
            end
            drive(0, 1, seq_mag[i]);
            check($sformatf("gapped%0d state", i), 16'(state_dbg), 16'(seq_st[i]));
            check($sformatf("gapped%0d det", i), 16'(fall_detected), (i == 6) ? 16'd1 : 16'd0);
            prev_st = seq_st[i];
        end
        drive(0, 0, 16'd0);
        check_all("gapped_end", 0, 1, 25000, 4);
        drive(1, 0, 16'd0);
        check_all("gapped_clr", 0, 0, 25000, 0);

        // async reset while in POST_IMPACT
        drive(0, 1, 16'd1000);
        drive(0, 1, 16'd1000);
        drive(0, 1, 16'd1000);
        drive(0, 1, 16'd30000);
        check_all("pre_reset", 0, 0, 30000, 3);
        @(negedge clk);
        mag_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 1, 16'd8192);
        check_all("after_reset", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
